conv1_relu: RTL and testbench



---
 rtl/cnn_pkg.sv | 23 ++
 rtl/mac_sat.sv | 64 ++++++
 rtl/conv1_relu.sv | 175 +++++++++++++++++
 tb/tb_conv1_relu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg: shared dimensions, widths and FSM state type for the CNN    |
// | datapath stages.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cnn_pkg;

  localparam int IMG_DIM  = 28;
  localparam int NUM_FILT = 16;
  localparam int KSZ      = 3;
  localparam int DATA_W   = 32;
  localparam int ACC_W    = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_sat: 64-bit wrapping multiply-accumulate with final arithmetic   |
// | shift, optional ReLU (CONV1_RELU_EN) and 32-bit saturation.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mac_sat
  import cnn_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] load_val,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    a_ext   = ACC_W'(a);
    b_ext   = ACC_W'(b);
    prod    = a_ext * b_ext;
    shifted = acc >>> FRAC_BITS;
    result  = shifted[DATA_W-1:0];
`ifdef CONV1_RELU_EN
    if (shifted < 0) begin
      result = '0;
    end else if (shifted > OUT_MAX) begin
      result = OUT_MAX[DATA_W-1:0];
    end
`else
    if (shifted > OUT_MAX) begin
      result = OUT_MAX[DATA_W-1:0];
    end else if (shifted < OUT_MIN) begin
      result = OUT_MIN[DATA_W-1:0];
    end
`endif
  end

  // Bias is preloaded in product scale so the final shift restores output scale.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(load_val) <<< FRAC_BITS;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv1_relu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv1_relu: 16-filter 3x3 convolution (pad 1) + bias + ReLU over a   |
// | 28x28 image using one time-multiplexed MAC. ReLU via CONV1_RELU_EN.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv1_relu
  import cnn_pkg::*;
#(
  parameter int FRAC_BITS = 8,
  parameter int DIM       = IMG_DIM,
  parameter int NFILT     = NUM_FILT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic signed [DATA_W-1:0] image        [0:DIM-1][0:DIM-1],
  input  logic signed [DATA_W-1:0] weights      [0:NFILT-1][0:KSZ-1][0:KSZ-1],
  input  logic signed [DATA_W-1:0] bias         [0:NFILT-1],
  output logic signed [DATA_W-1:0] feature_maps [0:NFILT-1][0:DIM-1][0:DIM-1]
);

  localparam int            CW      = $clog2(DIM);
  localparam int            FW      = $clog2(NFILT);
  localparam logic [CW-1:0] XY_LAST = CW'(DIM - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(NFILT - 1);

  conv_state_t state_q;
  conv_state_t state_d;

  logic [FW-1:0] f;
  logic [CW-1:0] y;
  logic [CW-1:0] x;
  logic [1:0]    ky;
  logic [1:0]    kx;

  logic                     last_tap;
  logic                     last_out;
  logic                     row_ok;
  logic                     col_ok;
  logic [CW-1:0]            row;
  logic [CW-1:0]            col;
  logic [FW-1:0]            f_next;
  logic signed [DATA_W-1:0] pixel;
  logic signed [DATA_W-1:0] load_bias;
  logic signed [DATA_W-1:0] result;
  logic                     acc_load;
  logic                     acc_en;

  // Padding: taps that fall outside the image feed a zero pixel into the MAC.
  always_comb begin
    last_tap = (ky == 2'd2) && (kx == 2'd2);
    last_out = (f == F_LAST) && (y == XY_LAST) && (x == XY_LAST);
    row_ok   = !(((ky == 2'd0) && (y == '0)) || ((ky == 2'd2) && (y == XY_LAST)));
    col_ok   = !(((kx == 2'd0) && (x == '0)) || ((kx == 2'd2) && (x == XY_LAST)));
    row      = y + CW'(ky) - CW'(1);
    col      = x + CW'(kx) - CW'(1);
    pixel    = (row_ok && col_ok) ? image[row][col] : '0;
    f_next   = ((y == XY_LAST) && (x == XY_LAST)) ? f + FW'(1) : f;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    acc_load  = 1'b0;
    acc_en    = 1'b0;
    load_bias = bias[0];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ACCUM;
          acc_load = 1'b1;
        end
      end
      S_ACCUM: begin
        busy   = 1'b1;
        acc_en = 1'b1;
        if (last_tap) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        load_bias = bias[f_next];
        if (last_out) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_ACCUM;
          acc_load = 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f  <= '0;
      y  <= '0;
      x  <= '0;
      ky <= '0;
      kx <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            f  <= '0;
            y  <= '0;
            x  <= '0;
            ky <= '0;
            kx <= '0;
          end
        end
        S_ACCUM: begin
          if (!last_tap) begin
            if (kx == 2'd2) begin
              kx <= '0;
              ky <= ky + 2'd1;
            end else begin
              kx <= kx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          ky <= '0;
          kx <= '0;
          f  <= f_next;
          if (x == XY_LAST) begin
            x <= '0;
            y <= (y == XY_LAST) ? '0 : y + CW'(1);
          end else begin
            x <= x + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_WRITE)) begin
      feature_maps[f][y][x] <= result;
    end
  end

  mac_sat #(
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .load    (acc_load),
    .load_val(load_bias),
    .en      (acc_en),
    .a       (pixel),
    .b       (weights[f][ky][kx]),
    .result  (result)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv1_relu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv1_relu: directed bench for conv1_relu on a reduced 5x5, 8-    |
// | filter instance; honours CONV1_RELU_EN. Revision: 1.0                |
// +----------------------------------------------------------------------+
module tb_conv1_relu;

  localparam int N    = 5;
  localparam int NF   = 8;
  localparam int FB   = 8;
  localparam int PASS = NF * N * N * 10;
`ifdef CONV1_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic signed [31:0] image   [0:N-1][0:N-1];
  logic signed [31:0] weights [0:NF-1][0:2][0:2];
  logic signed [31:0] bias    [0:NF-1];
  logic signed [31:0] fm      [0:NF-1][0:N-1][0:N-1];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                 sc;
    int                 f;
    int                 y;
    int                 x;
    logic signed [63:0] exp;
  } vec_t;
  vec_t vecs [0:13];

  always #5 clk = ~clk;

  conv1_relu #(
    .FRAC_BITS(FB),
    .DIM      (N),
    .NFILT    (NF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .image       (image),
    .weights     (weights),
    .bias        (bias),
    .feature_maps(fm)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] exp_of(input int sc, input int f, input int y, input int x);
    int taps;
    longint p;
    taps = ((y > 0 && y < N-1) ? 3 : 2) * ((x > 0 && x < N-1) ? 3 : 2);
    case (sc)
      0: return 64'(taps * 256);
      1: begin p = y*N + x - 12; return (RELU && p < 0) ? 64'sd0 : p; end
      2: begin p = -1000 + f*200; return (RELU && p < 0) ? 64'sd0 : p; end
      default: return (taps == 4) ? (RELU ? 64'sd0 : -64'sd67108864) : 64'sd2147483647;
    endcase
  endfunction

  task automatic set_inputs(input int sc);
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        image[y][x] = (sc == 0) ? 256 : (sc == 1) ? (y*N + x - 12) : (sc == 2) ? 0 : 32'h7fffffff;
    for (int f = 0; f < NF; f++) begin
      bias[f] = (sc == 2) ? (-1000 + f*200) : 0;
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          weights[f][ky][kx] = (sc == 1) ? ((ky == 1 && kx == 1) ? 256 : 0)
                             : (sc == 3) ? 32'h7fffffff : 256;
    end
  endtask

  task automatic check_maps(input int sc);
    for (int i = 0; i < 14; i++)
      if (vecs[i].sc == sc)
        check($sformatf("vec%0d", i), fm[vecs[i].f][vecs[i].y][vecs[i].x], vecs[i].exp);
    for (int f = 0; f < NF; f++)
      for (int y = 0; y < N; y++)
        for (int x = 0; x < N; x++)
          check($sformatf("map_s%0d_f%0d_y%0d_x%0d", sc, f, y, x), fm[f][y][x], exp_of(sc, f, y, x));
  endtask

  // Cycle n is the interval after edge n-1, with edge 0 accepting start.
  task automatic run_pass(input bit extra);
    int  done_cyc;
    bit  busy_err;
    bit  idle_err;
    logic busy_at_done;
    done_cyc     = -1;
    busy_err     = 1'b0;
    idle_err     = 1'b0;
    busy_at_done = 1'bx;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= PASS + 50 && done_cyc < 0; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc     = n;
        busy_at_done = busy;
      end else if (busy !== (n <= PASS)) begin
        busy_err = 1'b1;
      end
      start = extra && (n == 50 || n == PASS + 1);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) idle_err = 1'b1;
      start = 1'b0;
    end
    check("done_cycle", done_cyc, PASS + 1);
    check("busy_window", busy_err, 0);
    check("busy_at_done", busy_at_done, 0);
    check("idle_after_done", idle_err, 0);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 1024};
    vecs[1]  = '{0, 3, 2, 2, 2304};
    vecs[2]  = '{0, 7, 0, 2, 1536};
    vecs[3]  = '{0, 5, 4, 4, 1024};
    vecs[4]  = '{1, 0, 0, 0, RELU ? 64'sd0 : -64'sd12};
    vecs[5]  = '{1, 2, 4, 4, 12};
    vecs[6]  = '{1, 7, 2, 1, RELU ? 64'sd0 : -64'sd1};
    vecs[7]  = '{2, 0, 1, 1, RELU ? 64'sd0 : -64'sd1000};
    vecs[8]  = '{2, 6, 3, 3, 200};
    vecs[9]  = '{2, 4, 0, 0, RELU ? 64'sd0 : -64'sd200};
    vecs[10] = '{2, 7, 4, 4, 400};
    vecs[11] = '{3, 1, 2, 2, 64'sd2147483647};
    vecs[12] = '{3, 3, 0, 2, 64'sd2147483647};
    vecs[13] = '{3, 0, 4, 4, RELU ? 64'sd0 : -64'sd67108864};

    set_inputs(0);
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;

    run_pass(1'b1);
    check_maps(0);

    set_inputs(1);
    run_pass(1'b0);
    check_maps(1);

    // Abort a pass with reset, then rerun it from scratch.
    set_inputs(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midpass_reset_busy", busy, 0);
    check("midpass_reset_done", done, 0);
    reset = 1'b0;
    run_pass(1'b0);
    check_maps(2);

    set_inputs(3);
    run_pass(1'b0);
    check_maps(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
